spi_xfer_ctrl: RTL

//  Transfer sequencer directly upstream of the 1-master/3-slave SPI shift core.

---
 rtl/spi_xfer_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_ctrl.sv
// Transfer sequencer in front of the 1-master/3-slave SPI shift core: accepts one
// byte + slave index, runs one full-byte exchange, then returns the captured byte.
module spi_xfer_ctrl #(
  parameter int DATA_W     = 8,
  parameter int NUM_SS     = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        tx_sel,
  output logic [DATA_W-1:0] data_inp,
  output logic              load,
  output logic              ss0,
  output logic              ss1,
  output logic              ss2,
  input  logic [DATA_W-1:0] master_data1,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [1:0]        rx_sel,
  output logic              busy,
  output logic              err_sel
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       NUM_SS_L = 3'(NUM_SS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_GAP     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_inp_q, data_inp_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [1:0]        rx_sel_q, rx_sel_d;
  logic              rx_valid_q, rx_valid_d;
  logic              err_sel_q, err_sel_d;
  logic              load_q, load_d;
  logic [2:0]        ss_q, ss_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              hs_s;

  assign hs_s = tx_valid && tx_ready_q;

  // Next-state logic; every output is then registered from the next state so it
  // changes on the same edge as the FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    sel_d      = sel_q;
    data_inp_d = data_inp_q;
    rx_data_d  = rx_data_q;
    rx_sel_d   = rx_sel_q;
    rx_valid_d = 1'b0;
    err_sel_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          data_inp_d = tx_data;
          sel_d      = tx_sel;
          if ({1'b0, tx_sel} < NUM_SS_L) begin
            state_d = S_LOAD;
          end else begin
            err_sel_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        rx_data_d  = master_data1;
        rx_sel_d   = sel_q;
        rx_valid_d = 1'b1;
        gap_d      = {GAP_W{1'b0}};
        if (GAP_CYCLES == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    load_d     = (state_d == S_LOAD);
    ss_d       = (state_d == S_SHIFT) ? (3'b001 << sel_d) : 3'b000;
    tx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and registered outputs; tx_ready comes out of reset high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      gap_q      <= {GAP_W{1'b0}};
      sel_q      <= 2'b00;
      data_inp_q <= {DATA_W{1'b0}};
      rx_data_q  <= {DATA_W{1'b0}};
      rx_sel_q   <= 2'b00;
      rx_valid_q <= 1'b0;
      err_sel_q  <= 1'b0;
      load_q     <= 1'b0;
      ss_q       <= 3'b000;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      sel_q      <= sel_d;
      data_inp_q <= data_inp_d;
      rx_data_q  <= rx_data_d;
      rx_sel_q   <= rx_sel_d;
      rx_valid_q <= rx_valid_d;
      err_sel_q  <= err_sel_d;
      load_q     <= load_d;
      ss_q       <= ss_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign data_inp = data_inp_q;
  assign load     = load_q;
  assign ss0      = ss_q[0];
  assign ss1      = ss_q[1];
  assign ss2      = ss_q[2];
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_sel   = rx_sel_q;
  assign busy     = busy_q;
  assign err_sel  = err_sel_q;

endmodule
